// File: rtl/transform_seq.sv
// Row sequencer for a two-pass 2-D transform: writes N rows into the transpose buffer, turns, reads
// them back out. Build with TSEQ_ERR_EN defined to enable the sticky start-misuse error flag.
module transform_seq #(
  parameter int unsigned ROWS_MAX = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  cfg_size,
  input  logic                        cfg_dct,
  input  logic                        cfg_idct,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  scl_size,
  output logic                        scl_dct,
  output logic                        scl_idct,
  output logic                        tbuf_wr,
  output logic                        tbuf_rd,
  output logic [$clog2(ROWS_MAX)-1:0] tbuf_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        err
);

  localparam int unsigned CntW = $clog2(ROWS_MAX);

  typedef enum logic [2:0] {StIdle, StPass1, StTurn, StPass2, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   row_cnt_q;
  logic [1:0]        size_q;
  logic              dct_q;
  logic              idct_q;
  logic [CntW-1:0]   last_row;

  // N-1 = (4 << size) - 1, built as a low-order mask so 32 rows never overflow the counter width.
  assign last_row = ~({CntW{1'b1}} << ({1'b0, size_q} + 3'd2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      size_q    <= '0;
      dct_q     <= 1'b0;
      idct_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            size_q    <= cfg_size;
            dct_q     <= cfg_dct;
            idct_q    <= cfg_idct;
            row_cnt_q <= '0;
            state_q   <= StPass1;
          end
        end
        StPass1: begin
          if (in_valid) begin
            if (row_cnt_q == last_row) begin
              row_cnt_q <= '0;
              state_q   <= StTurn;
            end else begin
              row_cnt_q <= row_cnt_q + CntW'(1);
            end
          end
        end
        StTurn: state_q <= StPass2;
        StPass2: begin
          if (out_ready) begin
            if (row_cnt_q == last_row) begin
              row_cnt_q <= '0;
              state_q   <= StDone;
            end else begin
              row_cnt_q <= row_cnt_q + CntW'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    tbuf_wr   = 1'b0;
    tbuf_rd   = 1'b0;
    scl_dct   = 1'b0;
    scl_idct  = 1'b0;
    busy      = 1'b0;
    pass      = 1'b0;
    done      = 1'b0;
    tbuf_addr = row_cnt_q;
    scl_size  = size_q;
    unique case (state_q)
      StIdle: ;
      StPass1: begin
        in_ready = 1'b1;
        tbuf_wr  = in_valid;
        scl_dct  = dct_q;
        scl_idct = idct_q;
        busy     = 1'b1;
      end
      StTurn: begin
        pass = 1'b1;
        busy = 1'b1;
      end
      StPass2: begin
        out_valid = 1'b1;
        tbuf_rd   = out_ready;
        // Second pass keeps the inverse flag; the forward second pass uses the fixed shift.
        scl_idct  = idct_q;
        pass      = 1'b1;
        busy      = 1'b1;
      end
      StDone: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TSEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start && (busy || (cfg_dct == cfg_idct))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
